// File: rtl/noc_pkg.sv
// Shared NoC definitions: router port codes, default sizing and small helpers
// used by every router block.
package noc_pkg;

    localparam logic [2:0] PORT_LOCAL = 3'b000;
    localparam logic [2:0] PORT_E     = 3'b001;
    localparam logic [2:0] PORT_W     = 3'b010;
    localparam logic [2:0] PORT_N     = 3'b011;
    localparam logic [2:0] PORT_S     = 3'b100;
    localparam logic [2:0] PORT_NONE  = 3'b111;

    localparam int N_IN_DEF       = 5;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int N_REGISTER_DEF = 3;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_arbiter_if.sv
// Bundle between one output arbiter and its neighbours: requests and flits
// from the input controllers, grants back, flit and flow control to the link.
interface output_arbiter_if
    import noc_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [N_IN-1:0]            req;
    logic [N_IN*DATA_WIDTH-1:0] data_in;
    logic [N_IN-1:0]            gnt;
    logic [DATA_WIDTH-1:0]      data_out;
    logic                       out_valid;
    logic                       credit_in;
    logic                       down_full;
    logic                       err;

    modport master (
        input  req, data_in, credit_in, down_full,
        output gnt, data_out, out_valid, err
    );

    modport slave (
        output req, data_in, credit_in, down_full,
        input  gnt, data_out, out_valid, err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from the top index back to zero.
module rr_pick
    import noc_pkg::*;
#(
    parameter  int N_IN  = N_IN_DEF,
    localparam int IDX_W = idx_width(N_IN)
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_IN-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_IN) s = s - N_IN;
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_IN; k++) begin
            cand = wrap_idx(ptr_i, k);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Round-robin arbiter for one router output port with a two-stage grant/capture
// pipeline. Define OUTPUT_ARB_CREDIT_EN for credit flow control; otherwise down_full gates grants.
module output_arbiter
    import noc_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    N_IN       = N_IN_DEF,
    parameter int                    N_REGISTER = N_REGISTER_DEF,
    parameter logic [N_REGISTER-1:0] PORT_ID    = N_REGISTER'(PORT_LOCAL),
    parameter int                    CREDITS    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(N_IN);

    // The port code only identifies the instance; the datapath is identical for every port.
    localparam logic [N_REGISTER-1:0] unused_port_id = PORT_ID;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      sel_q;
    logic                  sel_v_q;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  out_valid_q;

    logic                  can_send;
    logic                  grant;
    logic [N_IN-1:0]       pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    rr_pick #(.N_IN(N_IN)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Gating with rst drops gnt the moment reset asserts, not at the next edge.
    assign grant   = rst && can_send && pick_valid;
    assign bus.gnt = grant ? pick_gnt : '0;
    assign ptr_d   = (pick_idx == IDX_W'(N_IN - 1)) ? '0 : pick_idx + IDX_W'(1);

    always_comb begin
        data_out_d = '0;
        if (sel_v_q) data_out_d = bus.data_in[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            sel_q       <= '0;
            sel_v_q     <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every register see pre-edge values of the others.
            if (grant) begin
                ptr_q <= ptr_d;
                sel_q <= pick_idx;
            end
            sel_v_q     <= grant;
            data_out_q  <= data_out_d;
            out_valid_q <= sel_v_q;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;

`ifdef OUTPUT_ARB_CREDIT_EN
    localparam int                CNT_W   = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0] credit_q;
    logic             err_q;
    logic             unused_flow;

    assign can_send    = (credit_q != '0);
    assign unused_flow = bus.down_full;

    // A grant and a returned credit on the same edge cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q <= CNT_MAX;
            err_q    <= 1'b0;
        end else begin
            if (bus.credit_in && (credit_q == CNT_MAX)) err_q <= 1'b1;
            unique case ({grant, bus.credit_in})
                2'b10:   credit_q <= credit_q - CNT_W'(1);
                2'b01:   if (credit_q != CNT_MAX) credit_q <= credit_q + CNT_W'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    assign bus.err = err_q;
`else
    logic unused_flow;

    assign can_send    = !bus.down_full;
    assign unused_flow = bus.credit_in;
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed pinning checks plus randomized
// traffic compared every cycle against a behavioural round-robin model.
module tb_output_arbiter;
    import noc_pkg::*;

    localparam int N       = 5;
    localparam int DW      = 8;
    localparam int CREDITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    output_arbiter_if #(.N_IN(N), .DATA_WIDTH(DW)) bus ();

    output_arbiter #(
        .DATA_WIDTH (DW),
        .N_IN       (N),
        .N_REGISTER (3),
        .PORT_ID    (PORT_LOCAL),
        .CREDITS    (CREDITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, pending winner, output stage, credit count, error flag.
    int             m_ptr, m_sel, m_cred;
    bit             m_ov, m_err;
    logic [DW-1:0]  m_do;

    task automatic model_reset();
        m_ptr  = 0;
        m_sel  = -1;
        m_cred = CREDITS;
        m_ov   = 1'b0;
        m_err  = 1'b0;
        m_do   = '0;
    endtask

    initial begin : compare
        int            win;
        int            j;
        bit            send_ok;
        logic [N-1:0]  exp_gnt;
        logic [N*DW-1:0] d_snap;
        bit            c_snap, r_snap;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
`ifdef OUTPUT_ARB_CREDIT_EN
            send_ok = (m_cred != 0);
`else
            send_ok = !bus.down_full;
`endif
            win = -1;
            if (rst && send_ok) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (win < 0 && bus.req[j]) win = j;
                end
            end
            exp_gnt = '0;
            if (win >= 0) exp_gnt[win] = 1'b1;
            check("gnt", 32'(bus.gnt), 32'(exp_gnt));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("data_out", 32'(bus.data_out), 32'(m_do));
            check("err", 32'(bus.err), 32'(m_err));
            d_snap = bus.data_in;
            c_snap = bus.credit_in;
            r_snap = rst;
            @(posedge clk);
            if (r_snap) begin
                m_ov  = (m_sel >= 0);
                m_do  = m_ov ? d_snap[m_sel*DW +: DW] : '0;
                m_sel = win;
                if (win >= 0) m_ptr = (win + 1) % N;
`ifdef OUTPUT_ARB_CREDIT_EN
                if (c_snap && m_cred == CREDITS) m_err = 1'b1;
                m_cred = m_cred - ((win >= 0) ? 1 : 0) + (c_snap ? 1 : 0);
                if (m_cred > CREDITS) m_cred = CREDITS;
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        bus.data_in[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        cyc();
        rst           = 1'b0;
        bus.req       = '0;
        bus.credit_in = 1'b0;
        bus.down_full = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin : stimulus
        bus.req       = 5'b00100;
        bus.data_in   = '0;
        bus.credit_in = 1'b0;
        bus.down_full = 1'b0;

        // Reset state, with a live request that must stay masked.
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);

        // First transfer: grant at t, flit at t+1, output at t+2.
        cyc(); rst = 1'b1;
        @(negedge clk);
        check("first_gnt", 32'(bus.gnt), 32'h04);
        cyc(); bus.req = '0; set_lane(2, 8'hA6);
        @(negedge clk);
        check("first_t1_valid", 32'(bus.out_valid), 32'h0);
        cyc(); bus.req = 5'b11111;
        @(negedge clk);
        check("first_t2_valid", 32'(bus.out_valid), 32'h1);
        check("first_t2_data", 32'(bus.data_out), 32'hA6);
        check("ptr3_gnt", 32'(bus.gnt), 32'h08);

        // Full request for ten cycles: strict rotation, no idle cycle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.req       = 5'b11111;
            bus.credit_in = (k >= 1);
            @(negedge clk);
            check($sformatf("rr_order_%0d", k), 32'(bus.gnt), 32'(1) << (k % N));
            cyc();
        end
        bus.credit_in = 1'b0;

        // Wrap from the top index back to zero.
        do_reset();
        bus.req = 5'b01000;
        @(negedge clk);
        check("wrap_g3", 32'(bus.gnt), 32'h08);
        cyc(); bus.req = 5'b10001;
        @(negedge clk);
        check("wrap_g4", 32'(bus.gnt), 32'h10);
        cyc();
        @(negedge clk);
        check("wrap_g0", 32'(bus.gnt), 32'h01);
        cyc(); bus.req = '0;

`ifdef OUTPUT_ARB_CREDIT_EN
        // Credit exhaustion, single refill, and a refill on a granting edge.
        do_reset();
        bus.req = 5'b00001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("credit_drain_%0d", k), 32'(bus.gnt), (k < CREDITS) ? 32'h1 : 32'h0);
            cyc();
        end
        bus.credit_in = 1'b1;
        @(negedge clk);
        check("credit_refill_idle", 32'(bus.gnt), 32'h0);
        cyc(); bus.credit_in = 1'b0;
        @(negedge clk);
        check("credit_one_more", 32'(bus.gnt), 32'h1);
        cyc();
        @(negedge clk);
        check("credit_empty_again", 32'(bus.gnt), 32'h0);
        cyc(); bus.credit_in = 1'b1;
        cyc();
        @(negedge clk);
        check("credit_same_edge", 32'(bus.gnt), 32'h1);
        cyc(); bus.credit_in = 1'b0;
        @(negedge clk);
        check("credit_kept", 32'(bus.gnt), 32'h1);
        cyc();
        @(negedge clk);
        check("credit_spent", 32'(bus.gnt), 32'h0);
        check("credit_no_err", 32'(bus.err), 32'h0);

        // Overflow at full credit is sticky until reset.
        do_reset();
        bus.credit_in = 1'b1;
        cyc(); bus.credit_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("err_sticky_%0d", k), 32'(bus.err), 32'h1);
            cyc();
        end
        do_reset();
        @(negedge clk);
        check("err_cleared", 32'(bus.err), 32'h0);
`else
        // Downstream full blocks grants.
        do_reset();
        bus.req       = 5'b00010;
        bus.down_full = 1'b1;
        @(negedge clk);
        check("full_blocks", 32'(bus.gnt), 32'h0);
        cyc(); bus.down_full = 1'b0;
        @(negedge clk);
        check("full_released", 32'(bus.gnt), 32'h02);
        cyc(); bus.req = '0;
`endif

        // Reset one cycle after a grant discards the in-flight flit.
        do_reset();
        bus.req = 5'b00100;
        set_lane(2, 8'h5C);
        @(negedge clk);
        check("abort_gnt", 32'(bus.gnt), 32'h04);
        cyc(); bus.req = 5'b00100; rst = 1'b0;
        @(negedge clk);
        check("abort_gnt_masked", 32'(bus.gnt), 32'h0);
        check("abort_valid_rst", 32'(bus.out_valid), 32'h0);
        cyc(); rst = 1'b1; bus.req = '0;
        @(negedge clk);
        check("abort_valid_t2", 32'(bus.out_valid), 32'h0);
        cyc();
        @(negedge clk);
        check("abort_valid_t3", 32'(bus.out_valid), 32'h0);
        cyc(); bus.req = 5'b11111;
        @(negedge clk);
        check("abort_ptr0", 32'(bus.gnt), 32'h01);

        // Randomized traffic, checked by the model every cycle.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bus.req       = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            bus.data_in   = (N*DW)'({$urandom(), $urandom()});
            bus.down_full = ($urandom_range(0, 3) == 0);
            bus.credit_in = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
